// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//   Programmable seconds timer for the traffic-light controller. A start
//   request loads the number of seconds selected by `interval`. A prescaler
//   divides clk down to one tick per second. When the last second ends, the
//   block returns a one-cycle `expired` pulse.
//
//   Configuration macro: INTERVAL_TIMER_PROG_EN
//     defined   - base/extended/yellow times can be reloaded through Prog_Sync
//     undefined - the times are fixed at TB_DEF/TE_DEF/TY_DEF and the
//                 programming inputs are ignored (the ports remain)
//
// Ports
//   clk          in  1  system clock, rising edge
//   reset        in  1  asynchronous active-high reset
//   start_timer  in  1  single-cycle start/restart request
//   interval     in  3  interval select, sampled with start_timer
//   Prog_Sync    in  1  synchronized single-cycle programming strobe
//   param_sel    in  2  00 base, 01 extended, 10 yellow, 11 reserved
//   time_value   in  4  new time in seconds (0 is stored as 1)
//   expired      out 1  one-cycle pulse when the running interval ends
//   busy         out 1  high while an interval is running
//   remaining    out 5  seconds left in the running interval, 0 when idle
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter logic [3:0]  TB_DEF   = 4'd6,
  parameter logic [3:0]  TE_DEF   = 4'd3,
  parameter logic [3:0]  TY_DEF   = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [2:0] interval,
  input  logic       Prog_Sync,
  input  logic [1:0] param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       busy,
  output logic [4:0] remaining
);

  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW        = 5;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [CW-1:0] count;
  logic          busy_q;
  logic          expired_q;

  logic [3:0]    tb_r;
  logic [3:0]    te_r;
  logic [3:0]    ty_r;
  logic [CW-1:0] start_len_c;

`ifdef INTERVAL_TIMER_PROG_EN
  logic [3:0] time_value_c;

  // A zero time is stored as one second, so no interval can have zero length.
  assign time_value_c = (time_value == 4'd0) ? 4'd1 : time_value;

  // Parameter registers. A start in the same cycle still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_r <= TB_DEF;
      te_r <= TE_DEF;
      ty_r <= TY_DEF;
    end else if (Prog_Sync) begin
      case (param_sel)
        2'b00:   tb_r <= time_value_c;
        2'b01:   te_r <= time_value_c;
        2'b10:   ty_r <= time_value_c;
        default: ;
      endcase
    end
  end
`else
  logic unused_prog;

  // Fixed times; the programming inputs are deliberately left unused.
  assign tb_r        = TB_DEF;
  assign te_r        = TE_DEF;
  assign ty_r        = TY_DEF;
  assign unused_prog = ^{Prog_Sync, param_sel, time_value};
`endif

  // Decode the requested length in seconds. The double-base case is formed
  // at 5 bits, so the largest value (2 x 15 = 30) cannot overflow.
  always_comb begin
    start_len_c = {1'b0, tb_r};
    case (interval)
      3'b000:  start_len_c = {1'b0, tb_r};
      3'b001:  start_len_c = {1'b0, te_r};
      3'b010:  start_len_c = {1'b0, ty_r};
      3'b011:  start_len_c = {tb_r, 1'b0};
      default: start_len_c = {1'b0, tb_r};
    endcase
  end

  // Timer FSM. A start always wins, including over the final tick, and it
  // aborts a running interval without an expired pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      count     <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (start_timer) begin
        state  <= RUN;
        presc  <= '0;
        count  <= start_len_c;
        busy_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            presc  <= '0;
            count  <= '0;
            busy_q <= 1'b0;
          end
          RUN: begin
            if (presc == PRESC_LAST) begin
              presc <= '0;
              if (count == CW'(1)) begin
                state     <= IDLE;
                count     <= '0;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
              end else begin
                count <= count - CW'(1);
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: begin
            state  <= IDLE;
            presc  <= '0;
            count  <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign expired   = expired_q;
  assign busy      = busy_q;
  assign remaining = count;

endmodule

// File: tb/tb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_interval_timer
//   Directed bench for interval_timer with TICK_DIV = 4. Expected lengths
//   depend on whether INTERVAL_TIMER_PROG_EN is defined.
// -----------------------------------------------------------------------------
module tb_interval_timer;

  localparam int TD = 4;

`ifdef INTERVAL_TIMER_PROG_EN
  localparam int Y5 = 5;
  localparam int Y0 = 1;
  localparam int Y7 = 7;
  localparam int B9 = 9;
`else
  localparam int Y5 = 2;
  localparam int Y0 = 2;
  localparam int Y7 = 2;
  localparam int B9 = 6;
`endif

  logic       clk;
  logic       reset;
  logic       start_timer;
  logic [2:0] interval;
  logic       Prog_Sync;
  logic [1:0] param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       busy;
  logic [4:0] remaining;

  int checks;
  int errors;

  interval_timer #(
    .TICK_DIV(TD),
    .TB_DEF  (4'd6),
    .TE_DEF  (4'd3),
    .TY_DEF  (4'd2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_timer(start_timer),
    .interval   (interval),
    .Prog_Sync  (Prog_Sync),
    .param_sel  (param_sel),
    .time_value (time_value),
    .expired    (expired),
    .busy       (busy),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle around a single rising edge, then sample.
  task automatic drive(input logic st, input logic [2:0] code, input logic pg,
                       input logic [1:0] sel, input logic [3:0] tv);
    @(negedge clk);
    start_timer = st;
    interval    = code;
    Prog_Sync   = pg;
    param_sel   = sel;
    time_value  = tv;
    @(posedge clk);
    #1;
    start_timer = 1'b0;
    Prog_Sync   = 1'b0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] tv);
    drive(1'b0, 3'b000, 1'b1, sel, tv);
  endtask

  // Check the state right after the start edge.
  task automatic after_start(input string tag, input int n);
    chk({tag, ".rem0"}, 32'(remaining), 32'(n));
    chk({tag, ".busy0"}, 32'(busy), 32'd1);
    chk({tag, ".exp0"}, 32'(expired), 32'd0);
  endtask

  task automatic do_start(input string tag, input logic [2:0] code, input int n);
    drive(1'b1, code, 1'b0, 2'b00, 4'd0);
    after_start(tag, n);
  endtask

  // Follow an interval of n seconds from the start edge to one cycle past expiry.
  task automatic run(input string tag, input int n);
    int last;
    last = n * TD;
    for (int i = 1; i <= last + 1; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s.exp@%0d", tag, i), 32'(expired), (i == last) ? 32'd1 : 32'd0);
      chk($sformatf("%s.busy@%0d", tag, i), 32'(busy), (i < last) ? 32'd1 : 32'd0);
      chk($sformatf("%s.rem@%0d", tag, i), 32'(remaining),
          (i < last) ? 32'(n - i / TD) : 32'd0);
    end
  endtask

  // Advance n cycles with no expiry expected.
  task automatic quiet(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s.noexp@%0d", tag, i), 32'(expired), 32'd0);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    start_timer = 1'b0;
    interval    = 3'b000;
    Prog_Sync   = 1'b0;
    param_sel   = 2'b00;
    time_value  = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.exp", 32'(expired), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rem", 32'(remaining), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.busy", 32'(busy), 32'd0);

    // Base interval: 6 s = 24 cycles.
    do_start("base", 3'b000, 6);
    run("base", 6);

    // Double base: 12 s = 48 cycles.
    do_start("dbl", 3'b011, 12);
    run("dbl", 12);

    // Program yellow = 5.
    prog(2'b10, 4'd5);
    do_start("y5", 3'b010, Y5);
    run("y5", Y5);

    // Program yellow = 0, which is stored as 1.
    prog(2'b10, 4'd0);
    do_start("y0", 3'b010, Y0);
    run("y0", Y0);

    // Reset pulse restores the default times.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Restart after ten cycles: only the second interval expires.
    do_start("rs1", 3'b001, 3);
    quiet("rs1", 9);
    do_start("rs2", 3'b010, 2);
    run("rs2", 2);

    // Start coinciding with the final tick: no pulse, full new interval.
    do_start("ft1", 3'b010, 2);
    quiet("ft1", 7);
    do_start("ft2", 3'b000, 6);
    run("ft2", 6);

    // Program and start in the same cycle: the start uses the old yellow.
    drive(1'b1, 3'b010, 1'b1, 2'b10, 4'd7);
    after_start("pgst", 2);
    run("pgst", 2);
    do_start("y7", 3'b010, Y7);
    run("y7", Y7);

    // Reserved selector is ignored.
    prog(2'b11, 4'd9);
    do_start("rsv", 3'b000, 6);
    run("rsv", 6);

    // Program base = 9, then reset mid-interval.
    prog(2'b00, 4'd9);
    do_start("mid", 3'b000, B9);
    quiet("mid", 9);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.rst.exp", 32'(expired), 32'd0);
    chk("mid.rst.busy", 32'(busy), 32'd0);
    chk("mid.rst.rem", 32'(remaining), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid.post.exp@%0d", i), 32'(expired), 32'd0);
      chk($sformatf("mid.post.busy@%0d", i), 32'(busy), 32'd0);
    end

    // The base time reverted to the default.
    do_start("rev", 3'b000, 6);
    run("rev", 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
